dmem_lsu: RTL
=============

# dmem_lsu

Load/store initiator driving the data-memory port (`we`/`addr`/`wdata_sel`/`wdata`/`rdata`) from the CPU pipeline. Accepts one load or store request at a time and converts it into a byte-lane memory cycle. Loads run against a one-cycle synchronous-read memory; the read data is extracted and sign- or zero-extended before it is returned. Misaligned accesses raise an address-error response and never reach memory.

## Interface

- No parameters. Data width 32, address width 32, little-endian, 4 byte lanes.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; handshake when `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `req_unsigned` in 1: zero-extend loads (LBU/LHU); ignored for stores and words.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle pulse, request complete.
- `resp_rdata` out 32: extended load data; 0 for stores and exceptions.
- `resp_exc` out 2: 00 = ok, 01 = AdEL (misaligned load), 10 = AdES (misaligned store).
- `resp_badvaddr` out 32: faulting address when `resp_exc != 0`, else 0.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out 32: memory byte address; memory uses [31:2].
- `mem_wdata_sel` out 4: byte enables; bit k = byte lane k = bits [8k+7:8k].
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: word read; valid the cycle after `mem_addr` is presented.

## Operation

- States: IDLE, ACCESS, LWAIT, RESP.
- `req_ready` = (state == IDLE) || (state == RESP).
- Alignment check on accept:
  - half: misaligned if `addr[0]`.
  - word or size 11: misaligned if `addr[1:0] != 0`.
  - byte: never misaligned.
- Misaligned request goes directly to RESP with `resp_exc` set and `resp_badvaddr = req_addr`. There is no memory cycle, and `mem_we` stays 0.
- Aligned request goes to ACCESS. All request fields are registered, and the `mem_*` outputs are registered from them.
- Store lane mapping:
  - byte: `mem_wdata = {4{wdata[7:0]}}`, `sel = 4'b0001 << addr[1:0]`.
  - half: `mem_wdata = {2{wdata[15:0]}}`, `sel = addr[1] ? 4'b1100 : 4'b0011`.
  - word: `mem_wdata = wdata`, `sel = 4'b1111`.
- Loads drive `sel = 0`, `mem_we = 0`, and `mem_addr = req_addr`.
- State transitions:
  - ACCESS, store: `mem_we = 1` for exactly this cycle, then RESP.
  - ACCESS, load: LWAIT.
  - LWAIT: sample `mem_rdata`, select the lane by `addr[1:0]` (byte) or `addr[1]` (half), extend by `req_unsigned`, register into `resp_rdata`, then RESP.
- RESP: `resp_valid = 1` for one cycle.
  - If a new request handshakes in RESP, it is processed as if accepted in IDLE (next state ACCESS or RESP).
  - Otherwise the next state is IDLE.
- Outside RESP, `resp_valid`, `resp_rdata`, `resp_exc` and `resp_badvaddr` are 0.
- `mem_we` is 0 in every state except ACCESS for a store.
- `mem_addr` and `mem_wdata` hold their last values in IDLE.
- Reset values: state IDLE and every output 0. This includes `req_ready`, which is combinational and goes to 1 once the unit is in IDLE.
- Reset mid-operation: reset dominates any state and no response is produced.
  - A store whose ACCESS cycle coincides with `reset` may still commit in memory at that edge. Memory has no reset.
  - A pending load is discarded.

## Timing

- Request accepted at the edge ending cycle T.
- Misaligned: `resp_valid` in T+1.
- Store: `mem_we` high in T+1, write commits at the end of T+1, `resp_valid` in T+2.
- Load: address in T+1, `mem_rdata` sampled in T+2, `resp_valid` with data in T+3.
- Back-to-back requests accepted in RESP give a throughput of one store per 2 cycles and one load per 3 cycles.
- No combinational path from `req_*` to `mem_*` or `resp_*`.

## Test plan

- **Reset:** hold `reset` 2 cycles. Then all outputs are 0 and `req_ready = 1` in the first post-reset cycle.
- **SB:** `addr = 0x10010003`, `wdata = 0x000000A5`. In T+1: `mem_we = 1`, `sel = 1000`, `mem_wdata = 0xA5A5A5A5`. In T+2: `resp_valid`, `exc = 00`.
- **LH / LHU:** `addr = 0x10010002`, memory word `0x8001_7F00`.
  - LH: `resp_rdata = 0xFFFF8001` in T+3.
  - LHU: `resp_rdata = 0x00008001` in T+3.
- **Misaligned accesses:**
  - LW at `0x10010001`: `resp_exc = 01`, `badvaddr = 0x10010001` in T+1, `mem_we` never high.
  - SH at `0x10010003`: `resp_exc = 10`.
- **Back-to-back:** SW `0x12345678` to `0x10010000`, accepted in RESP, followed immediately by LB at `0x10010001`. Expect two `resp_valid` pulses 3 cycles apart and `resp_rdata = 0x00000056`.
- **Reset mid-load:** assert `reset` in LWAIT. No `resp_valid` ever appears, and the next request behaves normally.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit: turns one CPU load/store request at a time into a byte-lane
// cycle on a synchronous-read data memory, with alignment checking and load extension.
module dmem_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic [31:0] resp_badvaddr,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wdata_sel,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NB = DW / 8;

  localparam logic [1:0] EXC_OK   = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    LWAIT  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Request fields still needed after the memory address has been issued
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
  } req_t;

  state_t         state_q, state_d;
  req_t           req_q, req_d;

  logic           accept;
  logic           misaligned;

  logic           resp_valid_d;
  logic [DW-1:0]  resp_rdata_d;
  logic [1:0]     resp_exc_d;
  logic [AW-1:0]  resp_badvaddr_d;
  logic           mem_we_d;
  logic [AW-1:0]  mem_addr_d;
  logic [NB-1:0]  mem_sel_d;
  logic [DW-1:0]  mem_wdata_d;

  function automatic logic [NB-1:0] store_sel(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   store_sel = NB'(4'b0001 << lane);
      2'b01:   store_sel = lane[1] ? 4'b1100 : 4'b0011;
      default: store_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [DW-1:0] store_data(input logic [1:0] size, input logic [DW-1:0] wd);
    case (size)
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  // Pick the addressed byte/half out of the read word and extend it
  function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (size)
      2'b00:   load_extend = uns ? {{(DW-8){1'b0}}, b}  : {{(DW-8){b[7]}}, b};
      2'b01:   load_extend = uns ? {{(DW-16){1'b0}}, h} : {{(DW-16){h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  assign req_ready = !reset && ((state_q == IDLE) || (state_q == RESP));
  assign accept    = req_valid && req_ready;

  always_comb begin
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      default: misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = '0;
    resp_exc_d      = EXC_OK;
    resp_badvaddr_d = '0;
    mem_we_d        = 1'b0;
    mem_sel_d       = '0;
    mem_addr_d      = mem_addr;
    mem_wdata_d     = mem_wdata;

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          req_d = '{we: req_we, size: req_size, uns: req_unsigned, lane: req_addr[1:0]};
          if (misaligned) begin
            state_d         = RESP;
            resp_valid_d    = 1'b1;
            resp_exc_d      = req_we ? EXC_ADES : EXC_ADEL;
            resp_badvaddr_d = req_addr;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = req_addr;
            if (req_we) begin
              mem_we_d    = 1'b1;
              mem_sel_d   = store_sel(req_size, req_addr[1:0]);
              mem_wdata_d = store_data(req_size, req_wdata);
            end
          end
        end
      end
      ACCESS: begin
        if (req_q.we) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = LWAIT;
        end
      end
      LWAIT: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_extend(mem_rdata, req_q.size, req_q.lane, req_q.uns);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_exc      <= EXC_OK;
      resp_badvaddr <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata_sel <= '0;
      mem_wdata     <= '0;
    end else begin
      resp_valid    <= resp_valid_d;
      resp_rdata    <= resp_rdata_d;
      resp_exc      <= resp_exc_d;
      resp_badvaddr <= resp_badvaddr_d;
      mem_we        <= mem_we_d;
      mem_addr      <= mem_addr_d;
      mem_wdata_sel <= mem_sel_d;
      mem_wdata     <= mem_wdata_d;
    end
  end

endmodule
